mem_access_unit: RTL and testbench

- MEM-stage load/store engine of the RV32I pipeline.
- Sits between the EX/MEM register and the MEM/WB register, and drives the data-memory bus with a req/ack handshake.
- Generates byte strobes and lane-replicated store data; sign- or zero-extends load data.
- Stalls the pipeline while a bus access is outstanding, and flags misaligned/illegal accesses and bus timeouts.

---
 rtl/rv32_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MEM-stage load/store engine.
package rv32_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } mau_state_e;

    // Rejects unknown encodings, unsigned stores and misaligned halfword/word accesses.
    function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = is_store & f3[2];
            F3_H, F3_HU: bad = lane[0] | (is_store & f3[2]);
            F3_W:        bad = |lane;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction/extension.
module mem_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_lane,
    input  logic [31:0] i_store_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: strobes follow the byte offset, data is replicated across all lanes
    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
        case (i_st_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_st_lane;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_st_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend
    always_comb begin
        w_byte      = i_rdata[{i_ld_lane, 3'b000} +: 8];
        w_half      = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_load_data = i_rdata;
        case (i_ld_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one bus access per instruction, stalls until done.
module mem_access_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic        i_advance,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    output logic [31:0] o_load_data,
    output logic        o_mem_stall,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_e r_state;
    mau_state_e w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [3:0]       r_bus_wstrb;
    logic [31:0]      r_load_data;
    logic             r_bus_err;
    logic [2:0]       r_ld_funct3;
    logic [1:0]       r_ld_lane;

    logic        w_access;
    logic        w_is_store;
    logic        w_bad;
    logic        w_issue;
    logic        w_reject;
    logic        w_complete;
    logic        w_timeout;
    logic        w_release;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    // A simultaneous read+write is handled as a store
    assign w_access   = i_mem_read | i_mem_write;
    assign w_is_store = i_mem_write;
    assign w_bad      = access_bad(w_is_store, i_funct3, i_addr[1:0]);

    // Store steering uses the live EX/MEM operands; load steering uses the issue-time lane
    mem_lane_align u_lane_align (
        .i_st_funct3  (i_funct3),
        .i_st_lane    (i_addr[1:0]),
        .i_store_data (i_store_data),
        .i_ld_funct3  (r_ld_funct3),
        .i_ld_lane    (r_ld_lane),
        .i_rdata      (i_bus_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_ext)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state events; ack takes priority over timeout
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_reject     = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (i_bus_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (i_advance) begin
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers: bus request, captured load result, error flag, wait counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
            r_ld_funct3 <= '0;
            r_ld_lane   <= '0;
        end else begin
            if (w_issue) begin
                r_cnt       <= '0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_is_store;
                r_bus_addr  <= {i_addr[31:2], 2'b00};
                r_bus_wdata <= w_is_store ? w_wdata : 32'h0;
                r_bus_wstrb <= w_is_store ? w_wstrb : 4'b0000;
                r_ld_funct3 <= i_funct3;
                r_ld_lane   <= i_addr[1:0];
            end else if (w_reject) begin
                r_load_data <= '0;
            end else if (w_complete) begin
                r_bus_req <= 1'b0;
                if (!r_bus_we) begin
                    r_load_data <= w_load_ext;
                end
            end else if (w_timeout) begin
                r_bus_req   <= 1'b0;
                r_load_data <= '0;
                r_bus_err   <= 1'b1;
            end else if (w_release) begin
                r_bus_err <= 1'b0;
                r_cnt     <= '0;
            end

            if (r_state == REQ && !w_complete && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_wstrb = r_bus_wstrb;
    assign o_load_data = r_load_data;
    assign o_bus_err   = r_bus_err;

    // Combinational flags are forced low while reset is held, whatever EX/MEM presents
    assign o_mem_stall = i_rst & (w_issue | (r_state == REQ));
    assign o_misalign  = i_rst & w_reject;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with an expected-result scoreboard.
module tb_mem_access_unit;
    import rv32_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        advance = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] load_data;
    logic        mem_stall;
    logic        misalign;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_access_unit #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_store_data (store_data),
        .i_advance    (advance),
        .i_bus_ack    (bus_ack),
        .i_bus_rdata  (bus_rdata),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_wstrb  (bus_wstrb),
        .o_load_data  (load_data),
        .o_mem_stall  (mem_stall),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err)
    );

    typedef struct packed {
        logic [31:0] ld;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ld = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_bad(input logic wr, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a != 2'b00;
            3'b100:  return wr;
            3'b101:  return wr | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            3'b001:  return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * int'(a));
        case (f3)
            3'b000:  return sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
            3'b100:  return sh & 32'h0000_00FF;
            3'b001:  return sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
            3'b101:  return sh & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    // One instruction through MEM: issue, respond on the bus, retire with optional DONE hold
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdata,
                              input int wait_n, input bit no_ack, input int hold);
        logic bad;
        exp_t e;
        int   req_cnt;
        int   stall_cnt;
        int   guard;
        bad = m_bad(wr, f3, a[1:0]);
        @(posedge clk);
        #1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        advance    = 1'b0;
        @(negedge clk);
        check({nm, "/misalign"}, {31'h0, misalign}, {31'h0, bad});
        check({nm, "/stall_issue"}, {31'h0, mem_stall}, {31'h0, !bad});
        if (bad) begin
            check({nm, "/req_on_bad"}, {31'h0, bus_req}, 32'h0);
            e.ld   = 32'h0;
            e.err  = 1'b0;
            exp_ld = 32'h0;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            e = sb_q.pop_front();
            check({nm, "/ld_after_bad"}, load_data, e.ld);
            check({nm, "/req_after_bad"}, {31'h0, bus_req}, 32'h0);
            return;
        end
        if (no_ack) begin
            e.ld  = 32'h0;
            e.err = 1'b1;
        end else begin
            e.ld  = wr ? exp_ld : m_load(f3, a[1:0], rdata);
            e.err = 1'b0;
        end
        exp_ld = e.ld;
        sb_q.push_back(e);
        stall_cnt = 1;
        req_cnt   = 0;
        guard     = 0;
        while (guard < 300) begin
            @(negedge clk);
            guard++;
            if (!mem_stall) break;
            stall_cnt++;
            if (bus_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({nm, "/bus_addr"}, bus_addr, {a[31:2], 2'b00});
                    check({nm, "/bus_we"}, {31'h0, bus_we}, {31'h0, wr});
                    check({nm, "/wstrb"}, {28'h0, bus_wstrb}, wr ? {28'h0, m_strb(f3, a[1:0])}
                                                                 : 32'h0);
                    if (wr) check({nm, "/wdata"}, bus_wdata, m_wdata(f3, sd));
                end
                if (!no_ack && req_cnt == wait_n + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
        bus_ack = 1'b0;
        check({nm, "/done_reached"}, {31'h0, mem_stall}, 32'h0);
        check({nm, "/req_cycles"}, req_cnt, no_ack ? TO : wait_n + 1);
        check({nm, "/stall_cycles"}, stall_cnt, req_cnt + 1);
        check({nm, "/req_dropped"}, {31'h0, bus_req}, 32'h0);
        e = sb_q.pop_front();
        check({nm, "/load_data"}, load_data, e.ld);
        check({nm, "/bus_err"}, {31'h0, bus_err}, {31'h0, e.err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({nm, "/hold_req"}, {31'h0, bus_req}, 32'h0);
            check({nm, "/hold_stall"}, {31'h0, mem_stall}, 32'h0);
            check({nm, "/hold_ld"}, load_data, e.ld);
            check({nm, "/hold_err"}, {31'h0, bus_err}, {31'h0, e.err});
        end
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check({nm, "/err_cleared"}, {31'h0, bus_err}, 32'h0);
        check({nm, "/idle_stall"}, {31'h0, mem_stall}, 32'h0);
        check({nm, "/idle_ld"}, load_data, e.ld);
    endtask

    initial begin
        logic [2:0] f3_tab[5];
        logic [2:0] f3;
        logic       wr;
        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

        #2;
        check("rst/bus_req", {31'h0, bus_req}, 32'h0);
        check("rst/load_data", load_data, 32'h0);
        check("rst/stall", {31'h0, mem_stall}, 32'h0);
        check("rst/bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        run_access("lb", 1, 0, F3_B, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        run_access("sh", 0, 1, F3_H, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 0, 0);
        run_access("lw_mis", 1, 0, F3_W, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
        run_access("lhu", 1, 0, F3_HU, 32'h0000_3002, 32'h0, 32'h8001_0000, 0, 0, 0);
        // ack lands in the same cycle the counter expires: ack must win
        run_access("lw_wait", 1, 0, F3_W, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, 0, 2);
        run_access("lw_to", 1, 0, F3_W, 32'h0000_5000, 32'h0, 32'h0, 0, 1, 1);
        run_access("sb", 0, 1, F3_B, 32'h0000_6001, 32'h1234_5678, 32'h0, 1, 0, 0);
        run_access("lh", 1, 0, F3_H, 32'h0000_7002, 32'h0, 32'h8001_7FFF, 0, 0, 0);
        run_access("bad_f3", 1, 0, 3'b011, 32'h0000_7000, 32'h0, 32'h0, 0, 0, 0);
        run_access("sbu", 0, 1, F3_BU, 32'h0000_7000, 32'h55, 32'h0, 0, 0, 0);
        run_access("rw_st", 1, 1, F3_W, 32'h0000_8004, 32'hCAFE_F00D, 32'h0, 2, 0, 0);

        for (int i = 0; i < 8; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
            run_access("rnd", !wr, wr, f3, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 2)), 0, int'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a pending request
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        funct3   = F3_W;
        addr     = 32'h0000_9000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid/bus_req", {31'h0, bus_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst/bus_req", {31'h0, bus_req}, 32'h0);
        check("arst/stall", {31'h0, mem_stall}, 32'h0);
        check("arst/misalign", {31'h0, misalign}, 32'h0);
        check("arst/load_data", load_data, 32'h0);
        check("arst/bus_err", {31'h0, bus_err}, 32'h0);
        check("arst/bus_addr", bus_addr, 32'h0);
        check("arst/wstrb", {28'h0, bus_wstrb}, 32'h0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        exp_ld = 32'h0;
        sb_q.delete();
        run_access("post_rst", 1, 0, F3_BU, 32'h0000_A002, 32'h0, 32'h0099_0000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
